// File: rtl/vga_mode_sequencer.sv
// Time-shares one VGA output between the 640x480 and 320x480 generators using clock enables and hold-resets.
// Define VGA_SEQ_LOOP_EN to alternate modes until stop instead of ending after one 320 turn.
module vga_mode_sequencer #(
    parameter int FRAMES640  = 1,
    parameter int FRAMES320  = 1,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       done640,
    input  logic       done320,
    input  logic       hsync640,
    input  logic       vsync640,
    input  logic [7:0] r640,
    input  logic [7:0] g640,
    input  logic [7:0] b640,
    input  logic       hsync320,
    input  logic       vsync320,
    input  logic [7:0] r320,
    input  logic [7:0] g320,
    input  logic [7:0] b320,
    output logic       en640,
    output logic       en320,
    output logic       rst640,
    output logic       rst320,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic [1:0] mode,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic       seq_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN640 = 2'd1,
        GAP    = 2'd2,
        RUN320 = 2'd3
    } state_t;

    localparam logic [7:0] F640_L = 8'(FRAMES640);
    localparam logic [7:0] F320_L = 8'(FRAMES320);
    localparam logic [7:0] GAP_L  = 8'(GAP_CYCLES);

    state_t     state, state_nxt;
    logic       next_is_320, next_is_320_nxt;
    logic       stop_pending, stop_pending_nxt;
    logic [7:0] run_cnt;
    logic [7:0] gap_cnt;
    logic       counted, stop_req, last_frame, gap_end;

    logic       hsync_p1, vsync_p1;
    logic [7:0] r_p1, g_p1, b_p1;

    always_comb begin
        state_nxt       = state;
        next_is_320_nxt = next_is_320;
        counted    = (state == RUN640 && done640) || (state == RUN320 && done320);
        stop_req   = stop_pending || (stop && state != IDLE);
        last_frame = (state == RUN640) ? (run_cnt + 8'd1 == F640_L)
                                       : (run_cnt + 8'd1 == F320_L);
        gap_end    = (gap_cnt == GAP_L - 8'd1);

        case (state)
            IDLE: begin
                if (start) state_nxt = RUN640;
            end
            RUN640: begin
                if (counted) begin
                    if (stop_req) begin
                        state_nxt = IDLE;
                    end else if (last_frame) begin
                        state_nxt       = GAP;
                        next_is_320_nxt = 1'b1;
                    end
                end
            end
            RUN320: begin
                if (counted) begin
                    if (stop_req) begin
                        state_nxt = IDLE;
                    end else if (last_frame) begin
`ifdef VGA_SEQ_LOOP_EN
                        state_nxt       = GAP;
                        next_is_320_nxt = 1'b0;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    if (stop_req)         state_nxt = IDLE;
                    else if (next_is_320) state_nxt = RUN320;
                    else                  state_nxt = RUN640;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A stop is remembered until the sequence actually lands in IDLE.
        stop_pending_nxt = (state_nxt == IDLE) ? 1'b0 : stop_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            next_is_320  <= 1'b0;
            stop_pending <= 1'b0;
            run_cnt      <= 8'd0;
            gap_cnt      <= 8'd0;
            frame_cnt    <= 8'd0;
            seq_done     <= 1'b0;
        end else begin
            state        <= state_nxt;
            next_is_320  <= next_is_320_nxt;
            stop_pending <= stop_pending_nxt;
            seq_done     <= (state != IDLE) && (state_nxt == IDLE);
            frame_cnt    <= frame_cnt + {7'd0, counted};
            if (state_nxt != state) run_cnt <= 8'd0;
            else if (counted)       run_cnt <= run_cnt + 8'd1;
            gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    // Stage p1: registered output mux, blanked outside the run states.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            r_p1     <= 8'd0;
            g_p1     <= 8'd0;
            b_p1     <= 8'd0;
        end else if (state == RUN640) begin
            hsync_p1 <= hsync640;
            vsync_p1 <= vsync640;
            r_p1     <= r640;
            g_p1     <= g640;
            b_p1     <= b640;
        end else if (state == RUN320) begin
            hsync_p1 <= hsync320;
            vsync_p1 <= vsync320;
            r_p1     <= r320;
            g_p1     <= g320;
            b_p1     <= b320;
        end else begin
            hsync_p1 <= 1'b1;
            vsync_p1 <= 1'b1;
            r_p1     <= 8'd0;
            g_p1     <= 8'd0;
            b_p1     <= 8'd0;
        end
    end

    assign en640  = (state == RUN640);
    assign en320  = (state == RUN320);
    assign rst640 = (state != RUN640);
    assign rst320 = (state != RUN320);
    assign mode   = state;
    assign busy   = (state != IDLE);
    assign hsync  = hsync_p1;
    assign vsync  = vsync_p1;
    assign r      = r_p1;
    assign g      = g_p1;
    assign b      = b_p1;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Directed table-driven bench for vga_mode_sequencer (FRAMES640=2, FRAMES320=1, GAP_CYCLES=4).
module tb_vga_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop, done640, done320;
    logic       hsync640, vsync640, hsync320, vsync320;
    logic [7:0] r640, g640, b640, r320, g320, b320;
    logic       en640, en320, rst640, rst320, hsync, vsync, busy, seq_done;
    logic [7:0] r, g, b, frame_cnt;
    logic [1:0] mode;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_mode_sequencer #(
        .FRAMES640 (2),
        .FRAMES320 (1),
        .GAP_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .done640  (done640),
        .done320  (done320),
        .hsync640 (hsync640),
        .vsync640 (vsync640),
        .r640     (r640),
        .g640     (g640),
        .b640     (b640),
        .hsync320 (hsync320),
        .vsync320 (vsync320),
        .r320     (r320),
        .g320     (g320),
        .b320     (b320),
        .en640    (en640),
        .en320    (en320),
        .rst640   (rst640),
        .rst320   (rst320),
        .hsync    (hsync),
        .vsync    (vsync),
        .r        (r),
        .g        (g),
        .b        (b),
        .mode     (mode),
        .busy     (busy),
        .frame_cnt(frame_cnt),
        .seq_done (seq_done)
    );

    typedef struct {
        logic       rst, start, stop, d640, d320;
        logic [1:0] mode;
        logic [7:0] fcnt;
        logic       sdone;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic rs, logic st, logic sp, logic d6, logic d3,
                                logic [1:0] m, logic [7:0] f, logic sd);
        vec_t v;
        v.rst = rs; v.start = st; v.stop = sp; v.d640 = d6; v.d320 = d3;
        v.mode = m; v.fcnt = f; v.sdone = sd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step%0d got %0h want %0h", name, idx, got, exp);
        end
    endtask

    // Checks everything the spec derives from mode plus the pixel path, where prev_mode is
    // the state during the cycle whose generator inputs were captured.
    task automatic chk_all(input int idx, input logic [1:0] em, input logic [7:0] ef,
                           input logic esd, input logic [1:0] prev_mode, input logic was_rst);
        logic       ehs, evs;
        logic [7:0] er, eg, eb;
        chk("mode", idx, 32'(mode), 32'(em));
        chk("busy", idx, 32'(busy), 32'(em != 2'd0));
        chk("en640", idx, 32'(en640), 32'(em == 2'd1));
        chk("en320", idx, 32'(en320), 32'(em == 2'd3));
        chk("rst640", idx, 32'(rst640), 32'(em != 2'd1));
        chk("rst320", idx, 32'(rst320), 32'(em != 2'd3));
        chk("frame_cnt", idx, 32'(frame_cnt), 32'(ef));
        chk("seq_done", idx, 32'(seq_done), 32'(esd));
        if (!was_rst && prev_mode == 2'd1) begin
            ehs = 1'b0; evs = 1'b0; er = 8'hAA; eg = 8'h55; eb = 8'h0F;
        end else if (!was_rst && prev_mode == 2'd3) begin
            ehs = 1'b0; evs = 1'b1; er = 8'h11; eg = 8'h22; eb = 8'h33;
        end else begin
            ehs = 1'b1; evs = 1'b1; er = 8'h00; eg = 8'h00; eb = 8'h00;
        end
        chk("hsync", idx, 32'(hsync), 32'(ehs));
        chk("vsync", idx, 32'(vsync), 32'(evs));
        chk("r", idx, 32'(r), 32'(er));
        chk("g", idx, 32'(g), 32'(eg));
        chk("b", idx, 32'(b), 32'(eb));
    endtask

    initial begin
        logic [1:0] prev_mode;
        rst = 1'b1; start = 1'b0; stop = 1'b0; done640 = 1'b0; done320 = 1'b0;
        hsync640 = 1'b0; vsync640 = 1'b0; r640 = 8'hAA; g640 = 8'h55; b640 = 8'h0F;
        hsync320 = 1'b0; vsync320 = 1'b1; r320 = 8'h11; g320 = 8'h22; b320 = 8'h33;
        prev_mode = 2'd0;

`ifdef VGA_SEQ_LOOP_EN
        begin
            int  waited;
            logic left_idle;
            @(posedge clk); #1;
            chk_all(0, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
            @(negedge clk); rst = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            chk("loop_start_mode", 1, 32'(mode), 32'd1);
            @(negedge clk); start = 1'b0; done640 = 1'b1; done320 = 1'b1;
            waited = 0; left_idle = 1'b0;
            while (frame_cnt != 8'd255 && waited < 3000) begin
                @(posedge clk); #1;
                if (mode == 2'd0) left_idle = 1'b1;
                waited++;
            end
            chk("loop_reach255_timeout", 2, 32'(waited < 3000), 32'd1);
            chk("loop_never_idle", 3, 32'(left_idle), 32'd0);
            waited = 0;
            while (frame_cnt == 8'd255 && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("loop_wrap", 4, 32'(frame_cnt), 32'd0);
            waited = 0;
            while (mode != 2'd3 && waited < 20) begin
                @(posedge clk); #1;
                waited++;
            end
            chk("loop_in_run320", 5, 32'(mode), 32'd3);
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            chk_all(6, 2'd0, 8'd0, 1'b0, 2'd0, 1'b1);
            @(negedge clk); rst = 1'b0; done640 = 1'b0; done320 = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            @(negedge clk); start = 1'b0; stop = 1'b1;
            @(posedge clk); #1;
            @(negedge clk); stop = 1'b0; done640 = 1'b1;
            @(posedge clk); #1;
            chk_all(7, 2'd0, 8'd1, 1'b1, 2'd1, 1'b0);
        end
`else
        //   rst st sp d6 d3  mode fcnt sdone
        add(1, 0, 0, 0, 0, 2'd0, 8'd0,  0);  // 0  reset
        add(0, 1, 0, 0, 0, 2'd1, 8'd0,  0);  // 1  start -> RUN640
        add(0, 0, 0, 0, 0, 2'd1, 8'd0,  0);
        add(0, 0, 0, 1, 0, 2'd1, 8'd1,  0);  // 3  first 640 frame
        add(0, 0, 0, 0, 1, 2'd1, 8'd1,  0);  // 4  done320 ignored in RUN640
        add(0, 0, 0, 1, 0, 2'd2, 8'd2,  0);  // 5  last 640 frame -> GAP
        add(0, 0, 0, 0, 0, 2'd2, 8'd2,  0);
        add(0, 1, 0, 1, 1, 2'd2, 8'd2,  0);  // 7  dones/start ignored in GAP
        add(0, 0, 0, 0, 0, 2'd2, 8'd2,  0);  // 8  4th gap cycle
        add(0, 0, 0, 0, 0, 2'd3, 8'd2,  0);  // 9  RUN320
        add(0, 0, 0, 0, 1, 2'd0, 8'd3,  1);  // 10 end of sequence
        add(0, 0, 0, 1, 0, 2'd0, 8'd3,  0);  // 11 done640 in IDLE ignored
        add(0, 0, 1, 0, 1, 2'd0, 8'd3,  0);  // 12 stop in IDLE ignored
        add(0, 1, 1, 0, 0, 2'd1, 8'd3,  0);  // 13 start wins over stop
        add(0, 0, 0, 1, 0, 2'd1, 8'd4,  0);  // 14 stop was not latched
        add(0, 0, 1, 0, 0, 2'd1, 8'd4,  0);  // 15 stop mid RUN640
        add(0, 0, 0, 0, 0, 2'd1, 8'd4,  0);
        add(0, 0, 0, 1, 0, 2'd0, 8'd5,  1);  // 17 honoured at frame end, no GAP
        add(0, 0, 0, 0, 0, 2'd0, 8'd5,  0);
        add(0, 1, 0, 0, 0, 2'd1, 8'd5,  0);  // 19
        add(0, 0, 1, 1, 0, 2'd0, 8'd6,  1);  // 20 stop with done: counted and IDLE
        add(0, 0, 0, 0, 0, 2'd0, 8'd6,  0);
        add(0, 1, 0, 0, 0, 2'd1, 8'd6,  0);  // 22
        add(0, 0, 0, 1, 0, 2'd1, 8'd7,  0);
        add(0, 0, 0, 1, 0, 2'd2, 8'd8,  0);  // 24 GAP
        add(0, 0, 1, 0, 0, 2'd2, 8'd8,  0);  // 25 stop during GAP
        add(0, 1, 0, 0, 0, 2'd2, 8'd8,  0);  // 26 start outside IDLE ignored
        add(0, 0, 0, 0, 0, 2'd2, 8'd8,  0);
        add(0, 0, 0, 0, 0, 2'd0, 8'd8,  1);  // 28 IDLE at gap end
        add(0, 0, 0, 0, 0, 2'd0, 8'd8,  0);
        add(0, 1, 0, 0, 0, 2'd1, 8'd8,  0);  // 30
        add(0, 0, 0, 1, 0, 2'd1, 8'd9,  0);
        add(0, 0, 0, 1, 0, 2'd2, 8'd10, 0);
        add(0, 0, 0, 0, 0, 2'd2, 8'd10, 0);
        add(0, 0, 0, 0, 0, 2'd2, 8'd10, 0);
        add(0, 0, 0, 0, 0, 2'd2, 8'd10, 0);
        add(0, 0, 0, 0, 0, 2'd3, 8'd10, 0);  // 36 RUN320
        add(1, 0, 0, 0, 1, 2'd0, 8'd0,  0);  // 37 rst mid RUN320, no seq_done
        add(0, 0, 0, 0, 0, 2'd0, 8'd0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            done640 = vecs[i].d640; done320 = vecs[i].d320;
            @(posedge clk); #1;
            chk_all(i, vecs[i].mode, vecs[i].fcnt, vecs[i].sdone, prev_mode, vecs[i].rst);
            prev_mode = vecs[i].mode;
            @(negedge clk);
        end

        // Changing pixels inside RUN640 must follow with one cycle of latency.
        rst = 1'b0; start = 1'b1; done640 = 1'b0; done320 = 1'b0; stop = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0; r640 = 8'h12; g640 = 8'h34; b640 = 8'h56;
        @(posedge clk); #1;
        chk("lat_r", 100, 32'(r), 32'h12);
        chk("lat_g", 100, 32'(g), 32'h34);
        chk("lat_b", 100, 32'(b), 32'h56);
        @(negedge clk); r640 = 8'hAA;
        @(posedge clk); #1;
        chk("lat_r2", 101, 32'(r), 32'hAA);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
